// File: rtl/round_robin_binary_arbiter.sv
// rtl/round_robin_binary_arbiter.sv - round-robin arbiter with registered binary grant index and optional hold timeout
module round_robin_binary_arbiter #(
   parameter int REQ_COUNT   = 8,
   parameter int INDEX_WIDTH = 3,
   parameter int HOLD_LIMIT  = 0,
   parameter int HOLD_WIDTH  = 8
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic [REQ_COUNT-1:0]   i_requests,
   input  logic                   i_release,
   output logic [INDEX_WIDTH-1:0] o_grant_index,
   output logic                   o_grant_valid,
   output logic                   o_grant_expired
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   localparam logic [INDEX_WIDTH-1:0] LP_LAST_RESET = INDEX_WIDTH'(REQ_COUNT - 1);
   localparam logic [HOLD_WIDTH-1:0]  LP_HOLD_LIMIT = HOLD_WIDTH'(HOLD_LIMIT);
   // With the timeout disabled the counter simply parks at all-ones instead of wrapping.
   localparam logic [HOLD_WIDTH-1:0]  LP_HOLD_SAT   = (HOLD_LIMIT == 0) ? {HOLD_WIDTH{1'b1}}
                                                                        : LP_HOLD_LIMIT;

   state_t                 r_state;
   logic [INDEX_WIDTH-1:0] r_grant_index;
   logic                   r_grant_valid;
   logic                   r_grant_expired;
   logic [INDEX_WIDTH-1:0] r_last;
   logic [HOLD_WIDTH-1:0]  r_hold;

   state_t                 w_state_nxt;
   logic [INDEX_WIDTH-1:0] w_index_nxt;
   logic                   w_valid_nxt;
   logic                   w_expired_nxt;
   logic [INDEX_WIDTH-1:0] w_last_nxt;
   logic [HOLD_WIDTH-1:0]  w_hold_nxt;

   logic [REQ_COUNT-1:0]   w_holder_oh;
   logic                   w_holder_req;
   logic                   w_end_rel;
   logic                   w_end_wd;
   logic                   w_end_to;
   logic                   w_end_any;

   logic [REQ_COUNT-1:0]   w_search_req;
   logic [INDEX_WIDTH-1:0] w_start;
   logic [REQ_COUNT-1:0]   w_rot_req;
   logic [REQ_COUNT-1:0]   w_rot_gnt;
   logic [REQ_COUNT-1:0]   w_gnt_oh;
   logic [INDEX_WIDTH-1:0] w_win_index;
   logic                   w_win_any;
   logic                   w_have_winner;
   logic [INDEX_WIDTH-1:0] w_winner;

   // One-hot of the current holder; grant index never reaches REQ_COUNT so no out-of-range decode.
   always_comb begin
      w_holder_oh = '0;
      for (int i = 0; i < REQ_COUNT; i++) begin
         if (r_grant_index == INDEX_WIDTH'(i)) begin
            w_holder_oh[i] = 1'b1;
         end
      end
   end

   assign w_holder_req = |(i_requests & w_holder_oh);

   // Grant end conditions, only meaningful while holding a grant.
   assign w_end_rel = (r_state == S_GRANT) && i_release;
   assign w_end_wd  = (r_state == S_GRANT) && !w_holder_req;
   assign w_end_to  = (r_state == S_GRANT) && (HOLD_LIMIT != 0) && (r_hold == LP_HOLD_LIMIT);
   assign w_end_any = w_end_rel || w_end_wd || w_end_to;

   // While granted the holder is excluded from the search; on withdrawal its bit is already clear.
   assign w_search_req = (r_state == S_GRANT) ? (i_requests & ~w_holder_oh) : i_requests;

   // Search starts one past the last granted index, wrapping without wider arithmetic.
   assign w_start = (r_last == LP_LAST_RESET) ? '0 : (r_last + INDEX_WIDTH'(1));

   // Rotate the request vector so the start position lands on bit 0.
   always_comb begin
      w_rot_req = '0;
      for (int k = 0; k < REQ_COUNT; k++) begin
         if (w_start == INDEX_WIDTH'(k)) begin
            for (int j = 0; j < REQ_COUNT; j++) begin
               w_rot_req[j] = w_search_req[(j + k) % REQ_COUNT];
            end
         end
      end
   end

   // Fixed priority: lowest set bit of the rotated vector wins.
   always_comb begin
      logic l_found;
      l_found   = 1'b0;
      w_rot_gnt = '0;
      for (int j = 0; j < REQ_COUNT; j++) begin
         if (w_rot_req[j] && !l_found) begin
            w_rot_gnt[j] = 1'b1;
            l_found      = 1'b1;
         end
      end
   end

   // Rotate the one-hot winner back into requester numbering.
   always_comb begin
      w_gnt_oh = '0;
      for (int k = 0; k < REQ_COUNT; k++) begin
         if (w_start == INDEX_WIDTH'(k)) begin
            for (int j = 0; j < REQ_COUNT; j++) begin
               w_gnt_oh[(j + k) % REQ_COUNT] = w_rot_gnt[j];
            end
         end
      end
   end

   // One-hot to binary encode of the winner.
   always_comb begin
      w_win_index = '0;
      for (int i = 0; i < REQ_COUNT; i++) begin
         if (w_gnt_oh[i]) begin
            w_win_index = w_win_index | INDEX_WIDTH'(i);
         end
      end
   end

   assign w_win_any = |w_search_req;

   // When the masked search is empty but the holder still asks, it is re-granted.
   assign w_have_winner = w_win_any || ((r_state == S_GRANT) && w_holder_req);
   assign w_winner      = w_win_any ? w_win_index : r_grant_index;

   // Next-state and next-output decode for the IDLE/GRANT machine.
   always_comb begin
      w_state_nxt   = r_state;
      w_index_nxt   = r_grant_index;
      w_valid_nxt   = r_grant_valid;
      w_expired_nxt = 1'b0;
      w_last_nxt    = r_last;
      w_hold_nxt    = r_hold;
      case (r_state)
         S_IDLE: begin
            w_valid_nxt = 1'b0;
            if (w_win_any) begin
               w_state_nxt = S_GRANT;
               w_index_nxt = w_win_index;
               w_valid_nxt = 1'b1;
               w_last_nxt  = w_win_index;
               w_hold_nxt  = HOLD_WIDTH'(1);
            end
         end
         S_GRANT: begin
            if (w_end_any) begin
               // Release and withdrawal take precedence over the timeout for the expiry pulse.
               w_expired_nxt = w_end_to && !w_end_rel && !w_end_wd;
               if (w_have_winner) begin
                  w_state_nxt = S_GRANT;
                  w_index_nxt = w_winner;
                  w_valid_nxt = 1'b1;
                  w_last_nxt  = w_winner;
                  w_hold_nxt  = HOLD_WIDTH'(1);
               end else begin
                  w_state_nxt = S_IDLE;
                  w_valid_nxt = 1'b0;
                  w_hold_nxt  = '0;
               end
            end else if (r_hold != LP_HOLD_SAT) begin
               w_hold_nxt = r_hold + HOLD_WIDTH'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state         <= S_IDLE;
         r_grant_index   <= '0;
         r_grant_valid   <= 1'b0;
         r_grant_expired <= 1'b0;
         r_last          <= LP_LAST_RESET;
         r_hold          <= '0;
      end else begin
         r_state         <= w_state_nxt;
         r_grant_index   <= w_index_nxt;
         r_grant_valid   <= w_valid_nxt;
         r_grant_expired <= w_expired_nxt;
         r_last          <= w_last_nxt;
         r_hold          <= w_hold_nxt;
      end
   end

   assign o_grant_index   = r_grant_index;
   assign o_grant_valid   = r_grant_valid;
   assign o_grant_expired = r_grant_expired;

endmodule

// File: tb/tb_round_robin_binary_arbiter.sv
// tb/tb_round_robin_binary_arbiter.sv - scoreboard bench for round_robin_binary_arbiter
module tb_round_robin_binary_arbiter;

   typedef struct {
      int         tag;
      logic       v;
      logic [2:0] i;
      logic       e;
      logic       c0;
      logic [2:0] i0;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       rel;

   logic [2:0] t_index;
   logic       t_valid;
   logic       t_expired;
   logic [2:0] n_index;
   logic       n_valid;
   logic       n_expired;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   tag   = 0;

   always #5 clk = ~clk;

   round_robin_binary_arbiter #(
      .REQ_COUNT(8), .INDEX_WIDTH(3), .HOLD_LIMIT(4), .HOLD_WIDTH(8)
   ) u_dut (
      .i_clock(clk), .i_reset(rst), .i_requests(req), .i_release(rel),
      .o_grant_index(t_index), .o_grant_valid(t_valid), .o_grant_expired(t_expired)
   );

   round_robin_binary_arbiter #(
      .REQ_COUNT(8), .INDEX_WIDTH(3), .HOLD_LIMIT(0), .HOLD_WIDTH(8)
   ) u_dut_nolimit (
      .i_clock(clk), .i_reset(rst), .i_requests(req), .i_release(rel),
      .o_grant_index(n_index), .o_grant_valid(n_valid), .o_grant_expired(n_expired)
   );

   task automatic chk(input int t, input string what, input int act, input int want);
      n_cmp++;
      if (act != want) begin
         n_bad++;
         $display("FAIL step %0d %s: got %0d want %0d", t, what, act, want);
      end
   endtask

   // One clock: drive inputs, take the edge, queue the outputs expected after it.
   task automatic step(input logic s_rst, input logic [7:0] s_req, input logic s_rel,
                       input logic ev, input logic [2:0] ei, input logic ee,
                       input logic c0, input logic [2:0] ei0);
      exp_t x;
      rst = s_rst;
      req = s_req;
      rel = s_rel;
      @(posedge clk);
      #1;
      tag++;
      x.tag = tag; x.v = ev; x.i = ei; x.e = ee; x.c0 = c0; x.i0 = ei0;
      exp_q.push_back(x);
   endtask

   // Monitor: each falling edge pops the expectation for the outputs now presented.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk(mon_e.tag, "grant_valid", int'(t_valid), int'(mon_e.v));
         chk(mon_e.tag, "grant_index", int'(t_index), int'(mon_e.i));
         chk(mon_e.tag, "grant_expired", int'(t_expired), int'(mon_e.e));
         if (mon_e.c0) begin
            chk(mon_e.tag, "nolimit grant_valid", int'(n_valid), int'(mon_e.v));
            chk(mon_e.tag, "nolimit grant_index", int'(n_index), int'(mon_e.i0));
            chk(mon_e.tag, "nolimit grant_expired", int'(n_expired), 0);
         end
      end
   end

   initial begin
      // reset with all requesting, then first grant goes to index 0
      step(1, 8'hFF, 0, 0, 3'd0, 0, 1, 3'd0);
      step(1, 8'hFF, 0, 0, 3'd0, 0, 1, 3'd0);
      step(0, 8'hFF, 0, 1, 3'd0, 0, 1, 3'd0);
      // rotation with release every cycle
      for (int k = 1; k <= 8; k++) begin
         step(0, 8'hFF, 1, 1, 3'(k % 8), 0, 1, 3'(k % 8));
      end
      // wrap/skip with 0x81
      step(0, 8'h81, 0, 1, 3'd0, 0, 1, 3'd0);
      step(0, 8'h81, 1, 1, 3'd7, 0, 1, 3'd7);
      step(0, 8'h81, 1, 1, 3'd0, 0, 1, 3'd0);
      // withdrawal: index 3 takes over, then drops; release while idle ignored
      step(0, 8'h08, 0, 1, 3'd3, 0, 1, 3'd3);
      step(0, 8'h00, 0, 0, 3'd3, 0, 1, 3'd3);
      step(0, 8'h00, 1, 0, 3'd3, 0, 1, 3'd3);
      // timeout: index 1 for 4 cycles then index 2 with expiry pulse
      for (int k = 0; k < 4; k++) begin
         step(0, 8'h06, 0, 1, 3'd1, 0, 0, 3'd0);
      end
      step(0, 8'h06, 0, 1, 3'd2, 1, 0, 3'd0);
      step(0, 8'h06, 0, 1, 3'd2, 0, 0, 3'd0);
      // sole requester re-granted on timeout
      for (int k = 0; k < 4; k++) begin
         step(0, 8'h02, 0, 1, 3'd1, 0, 0, 3'd0);
      end
      step(0, 8'h02, 0, 1, 3'd1, 1, 0, 3'd0);
      // release coincident with timeout: no expiry pulse
      for (int k = 0; k < 3; k++) begin
         step(0, 8'h02, 0, 1, 3'd1, 0, 0, 3'd0);
      end
      step(0, 8'h06, 1, 1, 3'd2, 0, 0, 3'd0);
      // reset mid-grant of index 5 restores the last pointer
      step(0, 8'h20, 0, 1, 3'd5, 0, 0, 3'd0);
      step(1, 8'h20, 0, 0, 3'd0, 0, 1, 3'd0);
      step(0, 8'hFF, 0, 1, 3'd0, 0, 1, 3'd0);
      for (int k = 0; k < 3; k++) begin
         step(0, 8'hFF, 0, 1, 3'd0, 0, 1, 3'd0);
      end
      // limited instance times out, unlimited instance keeps index 0
      step(0, 8'hFF, 0, 1, 3'd1, 1, 1, 3'd0);
      step(0, 8'hFF, 0, 1, 3'd1, 0, 1, 3'd0);
      rst = 1'b0;
      req = 8'h00;
      rel = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk(0, "scoreboard drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
